// File: rtl/l2_set_wb_pkg.sv
// Shared L2 types and constants for the set write-back path.
// Also carries the write-back FSM encoding and a one-hot way helper.
package l2_set_wb_pkg;

    localparam int L2_WAYS        = 8;
    localparam int WORDS_PER_LINE = 4;
    localparam int L2_SET_BITS    = 8;
    localparam int WAY_BITS       = $clog2(L2_WAYS);
    localparam int BITS_PER_WORD  = 32;
    localparam int L2_TAG_BITS    = 20;
    localparam int HPROT_WIDTH    = 1;
    localparam int STATE_BITS     = 3;

    typedef logic [BITS_PER_WORD*WORDS_PER_LINE-1:0] line_t;
    typedef logic [L2_TAG_BITS-1:0]                  l2_tag_t;
    typedef logic [HPROT_WIDTH-1:0]                  hprot_t;
    typedef logic [STATE_BITS-1:0]                   state_t;
    typedef logic [L2_SET_BITS-1:0]                  l2_set_t;
    typedef logic [WAY_BITS-1:0]                     l2_way_t;
    typedef logic [L2_WAYS-1:0]                      l2_way_mask_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } l2_wb_state_t;

    function automatic l2_way_mask_t way_onehot(input l2_way_t way);
        way_onehot = {{(L2_WAYS-1){1'b0}}, 1'b1} << way;
    endfunction

endpackage

// File: rtl/l2_way_prio_enc.sv
// Lowest-set-bit encoder over a way mask; shared with victim selection.
// idx reads 0 when no bit is set, so any_set must qualify it.
module l2_way_prio_enc
    import l2_set_wb_pkg::*;
(
    input  logic [L2_WAYS-1:0]  mask,
    output logic [WAY_BITS-1:0] idx,
    output logic                any_set
);

    // scan from the top so the lowest set bit is the last to win
    always_comb begin
        idx     = {WAY_BITS{1'b0}};
        any_set = |mask;
        for (int i = L2_WAYS - 1; i >= 0; i--) begin
            idx = mask[i] ? l2_way_t'(i) : idx;
        end
    end

endmodule

// File: rtl/l2_set_wb.sv
// Serialises a modified L2 set snapshot into the localmem write port,
// one masked way per accepted write, in ascending way order.
module l2_set_wb
    import l2_set_wb_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wb_req_valid,
    output logic                                   wb_req_ready,
    input  l2_set_t                                wb_req_set,
    input  l2_way_mask_t                           wb_req_way_mask,
    input  line_t   [L2_WAYS-1:0]                  wb_req_line,
    input  l2_tag_t [L2_WAYS-1:0]                  wb_req_tag,
    input  hprot_t  [L2_WAYS-1:0]                  wb_req_hprot,
    input  state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0] wb_req_state,
    output logic                                   lmem_wr_en,
    input  logic                                   lmem_wr_ready,
    output l2_set_t                                lmem_wr_set,
    output l2_way_t                                lmem_wr_way,
    output line_t                                  lmem_wr_line,
    output l2_tag_t                                lmem_wr_tag,
    output hprot_t                                 lmem_wr_hprot,
    output state_t  [WORDS_PER_LINE-1:0]           lmem_wr_state,
    output logic                                   wb_busy,
    output logic                                   wb_done
);

    l2_wb_state_t                              state_r;
    l2_way_mask_t                              pending_r;
    l2_set_t                                   set_r;
    line_t   [L2_WAYS-1:0]                     line_r;
    l2_tag_t [L2_WAYS-1:0]                     tag_r;
    hprot_t  [L2_WAYS-1:0]                     hprot_r;
    state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0] wstate_r;
    logic                                      ready_r;
    logic                                      wr_en_r;
    logic                                      busy_r;
    logic                                      done_r;

    l2_way_t                                   cur_way_s;
    logic                                      any_set_s;
    l2_way_mask_t                              pending_clr_s;

    l2_way_prio_enc u_way_prio_enc (
        .mask    (pending_r),
        .idx     (cur_way_s),
        .any_set (any_set_s)
    );

    // pending mask as it would look once the current way is accepted
    always_comb begin
        pending_clr_s = pending_r & ~way_onehot(cur_way_s);
    end

    // write-back FSM, snapshot capture and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pending_r <= {L2_WAYS{1'b0}};
            set_r     <= {L2_SET_BITS{1'b0}};
            line_r    <= '0;
            tag_r     <= '0;
            hprot_r   <= '0;
            wstate_r  <= '0;
            ready_r   <= 1'b1;
            wr_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wb_req_valid) begin
                        set_r     <= wb_req_set;
                        pending_r <= wb_req_way_mask;
                        line_r    <= wb_req_line;
                        tag_r     <= wb_req_tag;
                        hprot_r   <= wb_req_hprot;
                        wstate_r  <= wb_req_state;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        if (wb_req_way_mask != {L2_WAYS{1'b0}}) begin
                            state_r <= WRITE;
                            wr_en_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (lmem_wr_ready) begin
                        pending_r <= pending_clr_s;
                        if (pending_clr_s == {L2_WAYS{1'b0}}) begin
                            state_r <= DONE;
                            wr_en_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= WRITE;
                        end
                    end else begin
                        state_r <= WRITE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    pending_r <= {L2_WAYS{1'b0}};
                    ready_r   <= 1'b1;
                    wr_en_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // write port payload: muxed from the snapshot, forced to zero when idle
    always_comb begin
        lmem_wr_set   = {L2_SET_BITS{1'b0}};
        lmem_wr_way   = {WAY_BITS{1'b0}};
        lmem_wr_line  = '0;
        lmem_wr_tag   = '0;
        lmem_wr_hprot = '0;
        lmem_wr_state = '0;
        if (wr_en_r && any_set_s) begin
            lmem_wr_set   = set_r;
            lmem_wr_way   = cur_way_s;
            lmem_wr_line  = line_r[cur_way_s];
            lmem_wr_tag   = tag_r[cur_way_s];
            lmem_wr_hprot = hprot_r[cur_way_s];
            lmem_wr_state = wstate_r[cur_way_s];
        end else begin
            lmem_wr_way   = {WAY_BITS{1'b0}};
        end
    end

    assign wb_req_ready = ready_r;
    assign lmem_wr_en   = wr_en_r;
    assign wb_busy      = busy_r;
    assign wb_done      = done_r;

endmodule
